// File: rtl/bfly_sdf8_ctrl.sv
// -----------------------------------------------------------------------------
// bfly_sdf8_ctrl
//
// Radix-2 single-path delay-feedback (SDF) butterfly controller for a
// 16-point stage with an external 8-deep feedback shift register.
//
// A frame is 16 consecutive valid samples x[0..15]:
//   - x[0..7]  (FILL)  are pushed into the feedback register. The differences
//              still pending from the previous frame come out of the register
//              and are emitted as difference samples.
//   - x[8..15] (BFLY)  are combined with x[k-8] from the register tap:
//              (a+b)>>>1 is emitted as a sum sample and (a-b)>>>1 is fed back.
//   - If no new frame follows immediately, FLUSH drains the 8 fed-back
//     differences while feeding zeros.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid            input sample strobe
//   in_r, in_i          signed complex input sample
//   sr_out_r, sr_out_i  tap of the external feedback shift register
//   sr_in_r, sr_in_i    combinational drive into the feedback shift register
//   out_r, out_i        registered signed complex result
//   out_valid           qualifies out_r/out_i
//   out_is_diff         1 = difference sample, 0 = sum sample
//   tw_idx              twiddle index for the downstream multiplier (0 on sums)
//   out_sof             first output derived from a frame (its first sum)
//   err                 sticky protocol-error flag, cleared only by reset
// -----------------------------------------------------------------------------
module bfly_sdf8_ctrl #(
    parameter int DATA_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_i,
    input  logic [DATA_W-1:0] sr_out_r,
    input  logic [DATA_W-1:0] sr_out_i,
    output logic [DATA_W-1:0] sr_in_r,
    output logic [DATA_W-1:0] sr_in_i,
    output logic [DATA_W-1:0] out_r,
    output logic [DATA_W-1:0] out_i,
    output logic              out_valid,
    output logic              out_is_diff,
    output logic [2:0]        tw_idx,
    output logic              out_sof,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        BFLY  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Floor-rounded half sum / half difference. One guard bit holds the full
    // result, so the arithmetic shift brings it back into DATA_W bits exactly.
    function automatic logic signed [DATA_W-1:0] half_sum(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        s = s >>> 1;
        return s[DATA_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] half_diff(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [DATA_W:0] d;
        d = {a[DATA_W-1], a} - {b[DATA_W-1], b};
        d = d >>> 1;
        return d[DATA_W-1:0];
    endfunction

    state_t state;
    state_t state_nxt;
    state_t phase;

    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic [2:0] fcnt;
    logic [2:0] fcnt_nxt;
    logic       pending;
    logic       pending_nxt;
    logic       err_nxt;

    logic signed [DATA_W-1:0] in_r_s;
    logic signed [DATA_W-1:0] in_i_s;
    logic signed [DATA_W-1:0] tap_r_s;
    logic signed [DATA_W-1:0] tap_i_s;

    logic signed [DATA_W-1:0] sr_in_r_p0;
    logic signed [DATA_W-1:0] sr_in_i_p0;
    logic signed [DATA_W-1:0] out_r_p0;
    logic signed [DATA_W-1:0] out_i_p0;
    logic                     vld_p0;
    logic                     diff_p0;
    logic [2:0]               tw_p0;
    logic                     sof_p0;

    assign in_r_s  = in_r;
    assign in_i_s  = in_i;
    assign tap_r_s = sr_out_r;
    assign tap_i_s = sr_out_i;

    assign sr_in_r = sr_in_r_p0;
    assign sr_in_i = sr_in_i_p0;

    // Stage p0: decode the cycle, drive the feedback register, form the result
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        fcnt_nxt    = fcnt;
        pending_nxt = pending;
        err_nxt     = err;
        sr_in_r_p0  = '0;
        sr_in_i_p0  = '0;
        out_r_p0    = '0;
        out_i_p0    = '0;
        vld_p0      = 1'b0;
        diff_p0     = 1'b0;
        tw_p0       = 3'd0;
        sof_p0      = 1'b0;

        // The registered state names the phase the *next* sample is expected
        // in. Two cycles are resolved by the current in_valid:
        //  - IDLE with a valid sample is already x[0] of a new frame.
        //  - BFLY with cnt wrapped to 0 is the frame boundary: a valid sample
        //    starts the next frame's FILL, otherwise this is FLUSH cycle 0.
        phase = state;
        if (state == IDLE && in_valid) begin
            phase = FILL;
        end
        if (state == BFLY && cnt == 4'd0) begin
            phase = in_valid ? FILL : FLUSH;
        end

        case (phase)
            IDLE: begin
                // feedback register sees zeros, nothing is emitted
            end

            FILL: begin
                if (in_valid) begin
                    sr_in_r_p0 = in_r_s;
                    sr_in_i_p0 = in_i_s;
                    out_r_p0   = tap_r_s;
                    out_i_p0   = tap_i_s;
                    vld_p0     = pending;
                    diff_p0    = 1'b1;
                    tw_p0      = cnt[2:0];
                    cnt_nxt    = cnt + 4'd1;
                    state_nxt  = (cnt == 4'd7) ? BFLY : FILL;
                end else begin
                    err_nxt     = 1'b1;
                    pending_nxt = 1'b0;
                    cnt_nxt     = 4'd0;
                    state_nxt   = IDLE;
                end
            end

            BFLY: begin
                if (in_valid) begin
                    out_r_p0   = half_sum(tap_r_s, in_r_s);
                    out_i_p0   = half_sum(tap_i_s, in_i_s);
                    sr_in_r_p0 = half_diff(tap_r_s, in_r_s);
                    sr_in_i_p0 = half_diff(tap_i_s, in_i_s);
                    vld_p0     = 1'b1;
                    sof_p0     = (cnt == 4'd8);
                    cnt_nxt    = cnt + 4'd1;
                    // cnt wraps to 0 and the state stays BFLY so the next
                    // cycle becomes the frame-boundary decision.
                    if (cnt == 4'd15) begin
                        pending_nxt = 1'b1;
                    end
                end else begin
                    err_nxt     = 1'b1;
                    pending_nxt = 1'b0;
                    cnt_nxt     = 4'd0;
                    state_nxt   = IDLE;
                end
            end

            FLUSH: begin
                // Samples arriving while draining are flagged and dropped.
                if (in_valid) begin
                    err_nxt = 1'b1;
                end
                out_r_p0 = tap_r_s;
                out_i_p0 = tap_i_s;
                vld_p0   = pending;
                diff_p0  = 1'b1;
                tw_p0    = fcnt;
                fcnt_nxt = fcnt + 3'd1;
                if (fcnt == 3'd7) begin
                    pending_nxt = 1'b0;
                    state_nxt   = IDLE;
                end else begin
                    state_nxt   = FLUSH;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Stage p1: registered control state and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            fcnt        <= 3'd0;
            pending     <= 1'b0;
            err         <= 1'b0;
            out_r       <= '0;
            out_i       <= '0;
            out_valid   <= 1'b0;
            out_is_diff <= 1'b0;
            tw_idx      <= 3'd0;
            out_sof     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            fcnt        <= fcnt_nxt;
            pending     <= pending_nxt;
            err         <= err_nxt;
            out_r       <= out_r_p0;
            out_i       <= out_i_p0;
            out_valid   <= vld_p0;
            out_is_diff <= diff_p0;
            tw_idx      <= tw_p0;
            out_sof     <= sof_p0;
        end
    end

endmodule

// File: tb/tb_bfly_sdf8_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bfly_sdf8_ctrl
//
// Self-checking bench for bfly_sdf8_ctrl. Provides the external 8-deep
// feedback shift register and compares every registered output against a
// frame-level reference model (sample buffer + queue of pending differences).
// -----------------------------------------------------------------------------
module tb_bfly_sdf8_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [14:0] in_r;
    logic [14:0] in_i;
    logic [14:0] sr_out_r;
    logic [14:0] sr_out_i;
    logic [14:0] sr_in_r;
    logic [14:0] sr_in_i;
    logic [14:0] out_r;
    logic [14:0] out_i;
    logic        out_valid;
    logic        out_is_diff;
    logic [2:0]  tw_idx;
    logic        out_sof;
    logic        err;

    bfly_sdf8_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_r       (in_r),
        .in_i       (in_i),
        .sr_out_r   (sr_out_r),
        .sr_out_i   (sr_out_i),
        .sr_in_r    (sr_in_r),
        .sr_in_i    (sr_in_i),
        .out_r      (out_r),
        .out_i      (out_i),
        .out_valid  (out_valid),
        .out_is_diff(out_is_diff),
        .tw_idx     (tw_idx),
        .out_sof    (out_sof),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External feedback shift register: 8 deep, shifts every cycle.
    logic [14:0] fb_r [8];
    logic [14:0] fb_i [8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                fb_r[k] <= '0;
                fb_i[k] <= '0;
            end
        end else begin
            fb_r[0] <= sr_in_r;
            fb_i[0] <= sr_in_i;
            for (int k = 1; k < 8; k++) begin
                fb_r[k] <= fb_r[k-1];
                fb_i[k] <= fb_i[k-1];
            end
        end
    end

    assign sr_out_r = fb_r[7];
    assign sr_out_i = fb_i[7];

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int r;
        int i;
    } cplx_t;

    int    m_n;        // samples received in current frame (16 = complete)
    int    m_drain;    // flush cycles still to come
    bit    m_err;
    int    m_xr [16];
    int    m_xi [16];
    cplx_t m_pend [$]; // differences waiting to be emitted, oldest first

    bit e_vld;
    int e_r;
    int e_i;
    int e_diff;
    int e_tw;
    int e_sof;

    function automatic int floor_half(input int a);
        if (a < 0 && (a % 2) != 0) return a / 2 - 1;
        return a / 2;
    endfunction

    function automatic void model_reset();
        m_n     = 0;
        m_drain = 0;
        m_err   = 1'b0;
        m_pend.delete();
    endfunction

    function automatic void emit_diff(input int tw);
        cplx_t c;
        c      = m_pend.pop_front();
        e_vld  = 1'b1;
        e_r    = c.r;
        e_i    = c.i;
        e_diff = 1;
        e_tw   = tw;
    endfunction

    function automatic void model_step(input bit v, input int r, input int i);
        cplx_t c;
        e_vld = 1'b0; e_r = 0; e_i = 0; e_diff = 0; e_tw = 0; e_sof = 0;
        if (m_drain > 0) begin
            if (v) m_err = 1'b1;
            emit_diff(8 - m_drain);
            m_drain--;
        end else if (v) begin
            if (m_n == 16) m_n = 0;
            m_xr[m_n] = r;
            m_xi[m_n] = i;
            if (m_n < 8) begin
                if (m_pend.size() > 0) emit_diff(m_n);
            end else begin
                e_vld  = 1'b1;
                e_r    = floor_half(m_xr[m_n-8] + r);
                e_i    = floor_half(m_xi[m_n-8] + i);
                e_sof  = (m_n == 8) ? 1 : 0;
                c.r    = floor_half(m_xr[m_n-8] - r);
                c.i    = floor_half(m_xi[m_n-8] - i);
                m_pend.push_back(c);
            end
            m_n++;
        end else begin
            if (m_n == 16) begin
                m_n     = 0;
                m_drain = 7;
                emit_diff(0);
            end else if (m_n > 0) begin
                m_err = 1'b1;
                m_n   = 0;
                m_pend.delete();
            end
        end
    endfunction

    task automatic check_outputs();
        chk("err", int'(err), int'(m_err));
        chk("out_valid", int'(out_valid), int'(e_vld));
        if (e_vld) begin
            chk("out_r", int'($signed(out_r)), e_r);
            chk("out_i", int'($signed(out_i)), e_i);
            chk("out_is_diff", int'(out_is_diff), e_diff);
            chk("tw_idx", int'(tw_idx), e_tw);
            chk("out_sof", int'(out_sof), e_sof);
        end
    endtask

    // Drive one cycle starting just after a falling edge; check after the
    // next rising edge; return at the following falling edge.
    task automatic cycle(input bit v, input int r, input int i);
        in_valid = v;
        in_r     = 15'(r);
        in_i     = 15'(i);
        model_step(v, r, i);
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    function automatic int rnd_s15();
        return int'($urandom_range(0, 32767)) - 16384;
    endfunction

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) cycle(1'b0, rnd_s15(), rnd_s15());
    endtask

    task automatic rand_frame();
        for (int k = 0; k < 16; k++) cycle(1'b1, rnd_s15(), rnd_s15());
    endtask

    task automatic check_zero_outputs(input string pfx);
        chk({pfx, "_out_r"}, int'(out_r), 0);
        chk({pfx, "_out_i"}, int'(out_i), 0);
        chk({pfx, "_out_valid"}, int'(out_valid), 0);
        chk({pfx, "_out_is_diff"}, int'(out_is_diff), 0);
        chk({pfx, "_tw_idx"}, int'(tw_idx), 0);
        chk({pfx, "_out_sof"}, int'(out_sof), 0);
        chk({pfx, "_err"}, int'(err), 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_r     = '0;
        in_i     = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Ramp frame x[k] = k: sums k+4, then flush differences of -4.
        for (int k = 0; k < 16; k++) cycle(1'b1, k, 0);
        idle(12);

        // Two back-to-back frames, then drain.
        rand_frame();
        rand_frame();
        idle(10);

        // Extremes: sums of -1, differences of 16383 / -16384 on imag.
        for (int k = 0; k < 16; k++)
            cycle(1'b1, (k < 8) ? 16383 : -16384, (k < 8) ? -16384 : 16383);
        idle(10);

        // Clean random traffic; the gap lets a frame start right after FLUSH.
        for (int rd = 0; rd < 8; rd++) begin
            int nf;
            nf = int'($urandom_range(1, 3));
            for (int f = 0; f < nf; f++) rand_frame();
            idle(8 + int'($urandom_range(0, 3)));
        end

        // in_valid dropped at cnt 11.
        for (int k = 0; k < 11; k++) cycle(1'b1, rnd_s15(), rnd_s15());
        cycle(1'b0, 0, 0);
        idle(4);
        rand_frame();
        idle(10);

        // in_valid on the 3rd FLUSH cycle.
        rand_frame();
        cycle(1'b0, 0, 0);
        cycle(1'b0, 0, 0);
        cycle(1'b1, rnd_s15(), rnd_s15());
        idle(10);

        // Asynchronous reset while in BFLY.
        rand_frame();
        for (int k = 0; k < 12; k++) cycle(1'b1, rnd_s15(), rnd_s15());
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        rand_frame();
        idle(10);

        // Random traffic including protocol errors.
        for (int rd = 0; rd < 10; rd++) begin
            int len;
            len = int'($urandom_range(5, 40));
            for (int c = 0; c < len; c++)
                cycle(($urandom_range(0, 49) != 0), rnd_s15(), rnd_s15());
            idle(int'($urandom_range(0, 12)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
